// File: rtl/iexecute_if.sv
// Bundle between the ID/EX register, the execute stage and the EX/MEM register.
// The master side feeds E-stage values; the slave side is the execute stage itself.
interface iexecute_if #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
);
    logic               EnM;
    logic               FlushM;
    logic               RegWriteE;
    logic               MemWriteE;
    logic               JumpE;
    logic               BranchE;
    logic               ALUSrcE;
    logic [1:0]         ResultSrcE;
    logic [2:0]         ALUControlE;
    logic [2:0]         Funct3E;
    logic [RADDR_W-1:0] RdE;
    logic [XLEN-1:0]    RD1E;
    logic [XLEN-1:0]    RD2E;
    logic [XLEN-1:0]    PCE;
    logic [XLEN-1:0]    ImmExtE;
    logic [XLEN-1:0]    PCPlus4E;
    logic [1:0]         ForwardAE;
    logic [1:0]         ForwardBE;
    logic [XLEN-1:0]    ResultW;

    logic               PCSrcE;
    logic [XLEN-1:0]    PCTargetE;
    logic               RegWriteM;
    logic               MemWriteM;
    logic [1:0]         ResultSrcM;
    logic [RADDR_W-1:0] RdM;
    logic [XLEN-1:0]    ALUResultM;
    logic [XLEN-1:0]    WriteDataM;
    logic [XLEN-1:0]    PCPlus4M;

    modport master (
        output EnM, FlushM, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE,
               ResultSrcE, ALUControlE, Funct3E, RdE, RD1E, RD2E, PCE,
               ImmExtE, PCPlus4E, ForwardAE, ForwardBE, ResultW,
        input  PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RdM,
               ALUResultM, WriteDataM, PCPlus4M
    );

    modport slave (
        input  EnM, FlushM, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE,
               ResultSrcE, ALUControlE, Funct3E, RdE, RD1E, RD2E, PCE,
               ImmExtE, PCPlus4E, ForwardAE, ForwardBE, ResultW,
        output PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RdM,
               ALUResultM, WriteDataM, PCPlus4M
    );
endinterface

// File: rtl/iexecute.sv
// RISC-V execute stage: operand forwarding, ALU, branch/jump resolution,
// PC-target adder and the EX/MEM pipeline register.
module iexecute #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic       clk,
    input  logic       reset,
    iexecute_if.slave  bus
);
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] write_data;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] alu_result;
    logic            branch_cond;
    logic            ops_equal;
    logic            ops_less;

    // ALUResultM here is the value held before the edge, so back-to-back
    // dependent instructions see the previous EX result.
    always_comb begin
        src_a = bus.RD1E;
        case (bus.ForwardAE)
            2'b01:   src_a = bus.ResultW;
            2'b10:   src_a = bus.ALUResultM;
            default: src_a = bus.RD1E;
        endcase
    end

    always_comb begin
        write_data = bus.RD2E;
        case (bus.ForwardBE)
            2'b01:   write_data = bus.ResultW;
            2'b10:   write_data = bus.ALUResultM;
            default: write_data = bus.RD2E;
        endcase
    end

    assign src_b = bus.ALUSrcE ? bus.ImmExtE : write_data;

    always_comb begin
        alu_result = '0;
        case (bus.ALUControlE)
            3'b000:  alu_result = src_a + src_b;
            3'b001:  alu_result = src_a - src_b;
            3'b010:  alu_result = src_a & src_b;
            3'b011:  alu_result = src_a | src_b;
            3'b100:  alu_result = src_a ^ src_b;
            3'b101:  alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            3'b110:  alu_result = src_a << src_b[4:0];
            3'b111:  alu_result = src_a >> src_b[4:0];
            default: alu_result = '0;
        endcase
    end

    // Branches compare the two forwarded register operands, never the immediate.
    assign ops_equal = (src_a == write_data);
    assign ops_less  = ($signed(src_a) < $signed(write_data));

    always_comb begin
        branch_cond = 1'b0;
        case (bus.Funct3E)
            3'b000:  branch_cond = ops_equal;
            3'b001:  branch_cond = !ops_equal;
            3'b100:  branch_cond = ops_less;
            3'b101:  branch_cond = !ops_less;
            default: branch_cond = 1'b0;
        endcase
    end

    assign bus.PCSrcE    = bus.JumpE | (bus.BranchE & branch_cond);
    assign bus.PCTargetE = bus.PCE + bus.ImmExtE;

    // A flush turns the slot into a bubble even while the register is stalled.
    always_ff @(posedge clk) begin
        if (reset || bus.FlushM) begin
            bus.RegWriteM  <= 1'b0;
            bus.MemWriteM  <= 1'b0;
            bus.ResultSrcM <= '0;
            bus.RdM        <= '0;
            bus.ALUResultM <= '0;
            bus.WriteDataM <= '0;
            bus.PCPlus4M   <= '0;
        end else if (bus.EnM) begin
            bus.RegWriteM  <= bus.RegWriteE;
            bus.MemWriteM  <= bus.MemWriteE;
            bus.ResultSrcM <= bus.ResultSrcE;
            bus.RdM        <= bus.RdE;
            bus.ALUResultM <= alu_result;
            bus.WriteDataM <= write_data;
            bus.PCPlus4M   <= bus.PCPlus4E;
        end
    end
endmodule

// File: tb/tb_iexecute.sv
// Directed-vector bench for the execute stage: a table of single-cycle
// vectors followed by hand-written stall, flush and reset sequences.
module tb_iexecute;
    logic clk;
    logic reset;
    int   num_checks;
    int   num_fail;

    iexecute_if bus_if ();

    iexecute dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en, flush, rw, mw, jump, branch, alusrc;
        logic [1:0]  rs, fa, fb;
        logic [2:0]  ctl, f3;
        logic [4:0]  rd;
        logic [31:0] rd1, rd2, pc, imm, pc4, resw;
        logic        e_pcsrc;
        logic [31:0] e_tgt;
        logic        e_rw, e_mw;
        logic [1:0]  e_rs;
        logic [4:0]  e_rd;
        logic [31:0] e_alu, e_wd, e_pc4;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t blank();
        vec_t v;
        v.en = 1'b1; v.flush = 1'b0; v.rw = 1'b0; v.mw = 1'b0; v.jump = 1'b0;
        v.branch = 1'b0; v.alusrc = 1'b0; v.rs = 2'b00; v.fa = 2'b00; v.fb = 2'b00;
        v.ctl = 3'b000; v.f3 = 3'b000; v.rd = 5'd0;
        v.rd1 = 32'd0; v.rd2 = 32'd0; v.pc = 32'd0; v.imm = 32'd0; v.pc4 = 32'd0; v.resw = 32'd0;
        v.e_pcsrc = 1'b0; v.e_tgt = 32'd0; v.e_rw = 1'b0; v.e_mw = 1'b0; v.e_rs = 2'b00;
        v.e_rd = 5'd0; v.e_alu = 32'd0; v.e_wd = 32'd0; v.e_pc4 = 32'd0;
        return v;
    endfunction

    function automatic vec_t zeroExp(vec_t v);
        vec_t r = v;
        r.e_rw = 1'b0; r.e_mw = 1'b0; r.e_rs = 2'b00; r.e_rd = 5'd0;
        r.e_alu = 32'd0; r.e_wd = 32'd0; r.e_pc4 = 32'd0;
        return r;
    endfunction

    task automatic checkOutput(input string tag, input string name,
                               input logic [31:0] act, input logic [31:0] exp);
        num_checks++;
        if (act !== exp) begin
            num_fail++;
            $display("[TB] FAIL %s %s: got %h expected %h", tag, name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus_if.EnM = v.en;          bus_if.FlushM = v.flush;
        bus_if.RegWriteE = v.rw;    bus_if.MemWriteE = v.mw;
        bus_if.JumpE = v.jump;      bus_if.BranchE = v.branch;
        bus_if.ALUSrcE = v.alusrc;  bus_if.ResultSrcE = v.rs;
        bus_if.ALUControlE = v.ctl; bus_if.Funct3E = v.f3;
        bus_if.RdE = v.rd;          bus_if.RD1E = v.rd1;
        bus_if.RD2E = v.rd2;        bus_if.PCE = v.pc;
        bus_if.ImmExtE = v.imm;     bus_if.PCPlus4E = v.pc4;
        bus_if.ForwardAE = v.fa;    bus_if.ForwardBE = v.fb;
        bus_if.ResultW = v.resw;
    endtask

    task automatic checkComb(input string tag, input vec_t v);
        checkOutput(tag, "PCSrcE", 32'(bus_if.PCSrcE), 32'(v.e_pcsrc));
        checkOutput(tag, "PCTargetE", bus_if.PCTargetE, v.e_tgt);
    endtask

    task automatic checkM(input string tag, input vec_t v);
        checkOutput(tag, "RegWriteM", 32'(bus_if.RegWriteM), 32'(v.e_rw));
        checkOutput(tag, "MemWriteM", 32'(bus_if.MemWriteM), 32'(v.e_mw));
        checkOutput(tag, "ResultSrcM", 32'(bus_if.ResultSrcM), 32'(v.e_rs));
        checkOutput(tag, "RdM", 32'(bus_if.RdM), 32'(v.e_rd));
        checkOutput(tag, "ALUResultM", bus_if.ALUResultM, v.e_alu);
        checkOutput(tag, "WriteDataM", bus_if.WriteDataM, v.e_wd);
        checkOutput(tag, "PCPlus4M", bus_if.PCPlus4M, v.e_pc4);
    endtask

    task automatic applyStimulus(input string tag, input vec_t v);
        @(negedge clk);
        drive(v);
        #1;
        checkComb(tag, v);
        @(posedge clk);
        #1;
        checkM(tag, v);
    endtask

    task automatic buildTable();
        vec_t v;
        // add with immediate: 7 + (-3)
        v = blank(); v.rw = 1; v.rd = 5; v.rd1 = 7; v.alusrc = 1; v.imm = 32'hFFFF_FFFD; v.pc = 32'h40; v.pc4 = 32'h44;
        v.e_tgt = 32'h3D; v.e_rw = 1; v.e_rd = 5; v.e_alu = 4; v.e_pc4 = 32'h44; vecs.push_back(v);
        // slt signed: -1 < 1
        v = blank(); v.rw = 1; v.rd = 6; v.ctl = 3'b101; v.rd1 = 32'hFFFF_FFFF; v.rd2 = 1; v.pc = 32'h44; v.pc4 = 32'h48;
        v.e_tgt = 32'h44; v.e_rw = 1; v.e_rd = 6; v.e_alu = 1; v.e_wd = 1; v.e_pc4 = 32'h48; vecs.push_back(v);
        // seed ALUResultM = 0x10
        v = blank(); v.rw = 1; v.rd = 7; v.rd1 = 32'h10;
        v.e_rw = 1; v.e_rd = 7; v.e_alu = 32'h10; vecs.push_back(v);
        // forward A from ALUResultM overrides RD1E
        v = blank(); v.rw = 1; v.rd = 8; v.fa = 2'b10; v.rd1 = 32'h99;
        v.e_rw = 1; v.e_rd = 8; v.e_alu = 32'h10; vecs.push_back(v);
        // chained forwarding uses the pre-edge value each time
        v = blank(); v.fa = 2'b10; v.alusrc = 1; v.imm = 1; v.e_tgt = 1; v.e_alu = 32'h11; vecs.push_back(v);
        v = blank(); v.fa = 2'b10; v.alusrc = 1; v.imm = 1; v.e_tgt = 1; v.e_alu = 32'h12; vecs.push_back(v);
        // forward B from ResultW feeds store data
        v = blank(); v.mw = 1; v.fb = 2'b01; v.resw = 5; v.rd2 = 32'h77; v.alusrc = 1; v.imm = 8; v.rd1 = 2;
        v.e_tgt = 8; v.e_mw = 1; v.e_alu = 32'hA; v.e_wd = 5; vecs.push_back(v);
        // bne equal: not taken
        v = blank(); v.branch = 1; v.f3 = 3'b001; v.rd1 = 3; v.rd2 = 3; v.ctl = 3'b001; v.pc = 32'h100; v.imm = 32'h20; v.pc4 = 32'h104;
        v.e_tgt = 32'h120; v.e_alu = 0; v.e_wd = 3; v.e_pc4 = 32'h104; vecs.push_back(v);
        // bne 3 vs 4: taken
        v.rd2 = 4; v.e_pcsrc = 1; v.e_alu = 32'hFFFF_FFFF; v.e_wd = 4; vecs.push_back(v);
        // jal with equal operands
        v = blank(); v.jump = 1; v.rw = 1; v.rd = 1; v.rs = 2'b10; v.rd1 = 3; v.rd2 = 3; v.pc = 32'h100; v.imm = 32'h20; v.pc4 = 32'h104;
        v.e_pcsrc = 1; v.e_tgt = 32'h120; v.e_rw = 1; v.e_rd = 1; v.e_rs = 2'b10; v.e_alu = 6; v.e_wd = 3; v.e_pc4 = 32'h104; vecs.push_back(v);
        // beq equal: taken
        v = blank(); v.branch = 1; v.f3 = 3'b000; v.rd1 = 3; v.rd2 = 3; v.ctl = 3'b001; v.pc = 32'h100; v.imm = 32'h20;
        v.e_pcsrc = 1; v.e_tgt = 32'h120; v.e_wd = 3; vecs.push_back(v);
        // blt -2 < 1: taken
        v = blank(); v.branch = 1; v.f3 = 3'b100; v.rd1 = 32'hFFFF_FFFE; v.rd2 = 1; v.ctl = 3'b101;
        v.e_pcsrc = 1; v.e_alu = 1; v.e_wd = 1; vecs.push_back(v);
        // bge -2 >= 1: not taken; xor
        v = blank(); v.branch = 1; v.f3 = 3'b101; v.rd1 = 32'hFFFF_FFFE; v.rd2 = 1; v.ctl = 3'b100;
        v.e_alu = 32'hFFFF_FFFF; v.e_wd = 1; vecs.push_back(v);
        // bge equal: taken; or
        v = blank(); v.branch = 1; v.f3 = 3'b101; v.rd1 = 5; v.rd2 = 5; v.ctl = 3'b011;
        v.e_pcsrc = 1; v.e_alu = 5; v.e_wd = 5; vecs.push_back(v);
        // unsupported funct3 with equal operands: not taken; and
        v = blank(); v.branch = 1; v.f3 = 3'b010; v.rd1 = 32'hF0F0; v.rd2 = 32'hF0F0; v.ctl = 3'b010;
        v.e_alu = 32'hF0F0; v.e_wd = 32'hF0F0; vecs.push_back(v);
        // srl 0x80000000 by 31
        v = blank(); v.ctl = 3'b111; v.rd1 = 32'h8000_0000; v.alusrc = 1; v.imm = 31; v.e_tgt = 31; v.e_alu = 1; vecs.push_back(v);
        // add wrap
        v = blank(); v.rd1 = 32'hFFFF_FFFF; v.alusrc = 1; v.imm = 1; v.e_tgt = 1; v.e_alu = 0; vecs.push_back(v);
        // sll by 4, then by 0x21 (only low five bits count)
        v = blank(); v.ctl = 3'b110; v.rd1 = 1; v.alusrc = 1; v.imm = 4; v.e_tgt = 4; v.e_alu = 32'h10; vecs.push_back(v);
        v = blank(); v.ctl = 3'b110; v.rd1 = 1; v.alusrc = 1; v.imm = 32'h21; v.e_tgt = 32'h21; v.e_alu = 2; vecs.push_back(v);
        // or register operands
        v = blank(); v.ctl = 3'b011; v.rd1 = 32'hF0; v.rd2 = 32'h0F; v.e_alu = 32'hFF; v.e_wd = 32'h0F; vecs.push_back(v);
        // forward code 11 behaves as 00
        v = blank(); v.fa = 2'b11; v.rd1 = 5; v.resw = 9; v.alusrc = 1; v.imm = 1; v.e_tgt = 1; v.e_alu = 6; vecs.push_back(v);
        // forward A from ResultW
        v = blank(); v.fa = 2'b01; v.resw = 32'h1000; v.alusrc = 1; v.imm = 1; v.e_tgt = 1; v.e_alu = 32'h1001; vecs.push_back(v);
        // sub wrap, slt with sign difference
        v = blank(); v.ctl = 3'b001; v.rd2 = 1; v.e_alu = 32'hFFFF_FFFF; v.e_wd = 1; vecs.push_back(v);
        v = blank(); v.ctl = 3'b101; v.rd1 = 1; v.rd2 = 32'hFFFF_FFFF; v.e_alu = 0; v.e_wd = 32'hFFFF_FFFF; vecs.push_back(v);
    endtask

    initial begin
        vec_t v;
        vec_t held;
        clk = 1'b0;
        reset = 1'b1;
        num_checks = 0;
        num_fail = 0;
        buildTable();

        // reset with random E-stage inputs
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            v = blank();
            v.rw = 1; v.mw = 1; v.rs = 2'($urandom_range(0, 3)); v.rd = 5'($urandom_range(1, 31));
            v.rd1 = $urandom; v.rd2 = $urandom; v.pc4 = $urandom; v.ctl = 3'($urandom_range(0, 7));
            drive(v);
            @(posedge clk);
            #1;
            checkM($sformatf("reset%0d", c), zeroExp(blank()));
        end
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) applyStimulus($sformatf("vec%0d", i), vecs[i]);

        // stall: three cycles of changing inputs must not disturb M outputs
        held = vecs[9];
        applyStimulus("preload", held);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            v = vecs[c];
            v.en = 1'b0;
            v.rd1 = 32'(100 + c);
            drive(v);
            @(posedge clk);
            #1;
            checkM($sformatf("hold%0d", c), held);
        end

        // flush while stalled
        v = vecs[0]; v.en = 1'b0; v.flush = 1'b1;
        applyStimulus("flush_stall", zeroExp(v));

        // flush while enabled
        applyStimulus("preload2", held);
        v = held; v.flush = 1'b1;
        applyStimulus("flush_en", zeroExp(v));

        // reset mid-stream: comb outputs still track inputs
        applyStimulus("preload3", vecs[8]);
        @(negedge clk);
        reset = 1'b1;
        drive(held);
        #1;
        checkComb("midreset", held);
        @(posedge clk);
        #1;
        checkM("midreset", zeroExp(held));
        @(negedge clk);
        reset = 1'b0;
        applyStimulus("recover", vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
        $finish;
    end
endmodule
